// File: rtl/mem_read_router.sv
// Read router: LSU read port to CLINT or system bus.
// One outstanding read, bounded by a timeout that yields SLVERR.
module mem_read_router #(
  parameter logic [31:0] CLINT_BASE     = 32'h0200_0000,
  parameter logic [31:0] CLINT_SIZE     = 32'h0001_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,

  input  logic [31:0] MEM_raddr,
  input  logic [2:0]  MEM_rsize,
  input  logic        MEM_raddr_valid,
  output logic        MEM_raddr_ready,
  output logic [63:0] MEM_rdata,
  output logic [1:0]  MEM_rresp,
  output logic        MEM_rdata_valid,
  input  logic        MEM_rdata_ready,

  output logic [31:0] CLINT_MEM_raddr,
  output logic [2:0]  CLINT_MEM_rsize,
  output logic        CLINT_MEM_raddr_valid,
  input  logic        CLINT_MEM_raddr_ready,
  input  logic [63:0] CLINT_MEM_rdata,
  input  logic        CLINT_MEM_rdata_valid,
  output logic        CLINT_MEM_rdata_ready,

  output logic [31:0] BUS_raddr,
  output logic [2:0]  BUS_rsize,
  output logic        BUS_raddr_valid,
  input  logic        BUS_raddr_ready,
  input  logic [63:0] BUS_rdata,
  input  logic [1:0]  BUS_rresp,
  input  logic        BUS_rdata_valid,
  output logic        BUS_rdata_ready,

  output logic [7:0]  err_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST =
    TW'(TIMEOUT_CYCLES - 1);

  localparam logic [32:0] CLINT_LO =
    {1'b0, CLINT_BASE};
  localparam logic [32:0] CLINT_HI =
    {1'b0, CLINT_BASE} + {1'b0, CLINT_SIZE};

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    ERR
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [31:0]   addr_q;
  logic [2:0]    size_q;
  logic          sel_q;
  logic [TW-1:0] timer_q;

  logic          sel_in;
  logic          ar_hs;
  logic          stall;
  logic          expire;
  logic          timeout;

  logic          slv_ar_ready;
  logic          slv_rvalid;
  logic [63:0]   slv_rdata;
  logic [1:0]    slv_rresp;

  // 33-bit window compare so the upper bound cannot wrap
  assign sel_in =
    ({1'b0, MEM_raddr} >= CLINT_LO) &&
    ({1'b0, MEM_raddr} <  CLINT_HI);

  assign ar_hs  = MEM_raddr_valid && MEM_raddr_ready;
  assign stall  = MEM_rdata_valid && !MEM_rdata_ready;
  assign expire = (timer_q == T_LAST);

  // Return-path mux from the slave chosen at accept time
  always_comb begin
    slv_ar_ready = 1'b0;
    slv_rvalid   = 1'b0;
    slv_rdata    = '0;
    slv_rresp    = RESP_OKAY;
    unique case (1'b1)
      sel_q: begin
        slv_ar_ready = CLINT_MEM_raddr_ready;
        slv_rvalid   = CLINT_MEM_rdata_valid;
        slv_rdata    = CLINT_MEM_rdata;
        slv_rresp    = RESP_OKAY;
      end
      !sel_q: begin
        slv_ar_ready = BUS_raddr_ready;
        slv_rvalid   = BUS_rdata_valid;
        slv_rdata    = BUS_rdata;
        slv_rresp    = BUS_rresp;
      end
      default: ;
    endcase
  end

  // Next state and all channel outputs
  always_comb begin
    state_nx              = state;
    timeout               = 1'b0;
    MEM_raddr_ready       = 1'b0;
    MEM_rdata             = '0;
    MEM_rresp             = RESP_OKAY;
    MEM_rdata_valid       = 1'b0;
    CLINT_MEM_raddr       = addr_q;
    CLINT_MEM_rsize       = size_q;
    CLINT_MEM_raddr_valid = 1'b0;
    CLINT_MEM_rdata_ready = 1'b0;
    BUS_raddr             = addr_q;
    BUS_rsize             = size_q;
    BUS_raddr_valid       = 1'b0;
    BUS_rdata_ready       = 1'b0;
    unique case (state)
      IDLE: begin
        MEM_raddr_ready = !rst;
        if (MEM_raddr_valid) begin
          state_nx = ADDR;
        end
      end
      ADDR: begin
        CLINT_MEM_raddr_valid = sel_q;
        BUS_raddr_valid       = !sel_q;
        if (slv_ar_ready) begin
          state_nx = DATA;
        end else if (expire) begin
          state_nx = ERR;
          timeout  = 1'b1;
        end
      end
      DATA: begin
        MEM_rdata_valid       = slv_rvalid;
        MEM_rdata             = slv_rdata;
        MEM_rresp             = slv_rresp;
        CLINT_MEM_rdata_ready =
          sel_q && MEM_rdata_ready;
        BUS_rdata_ready       =
          !sel_q && MEM_rdata_ready;
        if (slv_rvalid && MEM_rdata_ready) begin
          state_nx = IDLE;
        end else if (expire && !slv_rvalid) begin
          state_nx = ERR;
          timeout  = 1'b1;
        end
      end
      ERR: begin
        MEM_rdata_valid = 1'b1;
        MEM_rresp       = RESP_SLVERR;
        if (MEM_rdata_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register; reset drops any transaction in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Capture request on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      size_q <= '0;
      sel_q  <= 1'b0;
    end else if (ar_hs) begin
      addr_q <= MEM_raddr;
      size_q <= MEM_rsize;
      sel_q  <= sel_in;
    end
  end

  // Timeout timer; frozen while the master backpressures
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
    end else if (state == IDLE) begin
      timer_q <= '0;
    end else if ((state == ADDR || state == DATA)
                 && !stall) begin
      timer_q <= timer_q + 1'b1;
    end
  end

  // Saturating count of timed-out transactions
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
    end else if (timeout && err_count != 8'hFF) begin
      err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_mem_read_router.sv
// Bench for mem_read_router: CLINT and bus models,
// scoreboard of expected read responses.
module tb_mem_read_router;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] MEM_raddr;
  logic [2:0]  MEM_rsize;
  logic        MEM_raddr_valid;
  logic        MEM_raddr_ready;
  logic [63:0] MEM_rdata;
  logic [1:0]  MEM_rresp;
  logic        MEM_rdata_valid;
  logic        MEM_rdata_ready;
  logic [31:0] CLINT_MEM_raddr;
  logic [2:0]  CLINT_MEM_rsize;
  logic        CLINT_MEM_raddr_valid;
  logic        CLINT_MEM_raddr_ready;
  logic [63:0] CLINT_MEM_rdata;
  logic        CLINT_MEM_rdata_valid;
  logic        CLINT_MEM_rdata_ready;
  logic [31:0] BUS_raddr;
  logic [2:0]  BUS_rsize;
  logic        BUS_raddr_valid;
  logic        BUS_raddr_ready;
  logic [63:0] BUS_rdata;
  logic [1:0]  BUS_rresp;
  logic        BUS_rdata_valid;
  logic        BUS_rdata_ready;
  logic [7:0]  err_count;

  mem_read_router dut (
    .clk                   (clk),
    .rst                   (rst),
    .MEM_raddr             (MEM_raddr),
    .MEM_rsize             (MEM_rsize),
    .MEM_raddr_valid       (MEM_raddr_valid),
    .MEM_raddr_ready       (MEM_raddr_ready),
    .MEM_rdata             (MEM_rdata),
    .MEM_rresp             (MEM_rresp),
    .MEM_rdata_valid       (MEM_rdata_valid),
    .MEM_rdata_ready       (MEM_rdata_ready),
    .CLINT_MEM_raddr       (CLINT_MEM_raddr),
    .CLINT_MEM_rsize       (CLINT_MEM_rsize),
    .CLINT_MEM_raddr_valid (CLINT_MEM_raddr_valid),
    .CLINT_MEM_raddr_ready (CLINT_MEM_raddr_ready),
    .CLINT_MEM_rdata       (CLINT_MEM_rdata),
    .CLINT_MEM_rdata_valid (CLINT_MEM_rdata_valid),
    .CLINT_MEM_rdata_ready (CLINT_MEM_rdata_ready),
    .BUS_raddr             (BUS_raddr),
    .BUS_rsize             (BUS_rsize),
    .BUS_raddr_valid       (BUS_raddr_valid),
    .BUS_raddr_ready       (BUS_raddr_ready),
    .BUS_rdata             (BUS_rdata),
    .BUS_rresp             (BUS_rresp),
    .BUS_rdata_valid       (BUS_rdata_valid),
    .BUS_rdata_ready       (BUS_rdata_ready),
    .err_count             (err_count)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
    bit          approx;
  } exp_t;

  exp_t sb[$];

  // Free-running mtime, cleared by reset
  logic [63:0] mtime;
  always @(posedge clk) begin
    if (rst) mtime <= '0;
    else     mtime <= mtime + 64'd1;
  end

  // CLINT model: answers only inside the mtime word
  function automatic bit in_mtime(input logic [31:0] a);
    return (a & ~32'h7) == 32'h0200_BFF8;
  endfunction

  logic        cpend;
  logic [63:0] cdata;
  int          clint_vcnt;
  assign CLINT_MEM_raddr_ready =
    CLINT_MEM_raddr_valid && in_mtime(CLINT_MEM_raddr);
  assign CLINT_MEM_rdata_valid = cpend;
  assign CLINT_MEM_rdata       = cdata;

  always @(posedge clk) begin
    if (rst) begin
      cpend <= 1'b0;
      cdata <= '0;
    end else if (CLINT_MEM_raddr_valid &&
                 CLINT_MEM_raddr_ready) begin
      cpend <= 1'b1;
      cdata <= mtime;
    end else if (cpend && CLINT_MEM_rdata_ready) begin
      cpend <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rst) clint_vcnt <= 0;
    else if (CLINT_MEM_raddr_valid)
      clint_vcnt <= clint_vcnt + 1;
  end

  // Bus model: address wait states, then one-cycle data
  int          bus_wait;
  bit          bus_mute;
  logic [63:0] bus_dat;
  logic [1:0]  bus_rsp;
  int          bcnt;
  logic        bpend;
  assign BUS_raddr_ready =
    BUS_raddr_valid && !bus_mute && (bcnt == bus_wait);
  assign BUS_rdata_valid = bpend;
  assign BUS_rdata       = bus_dat;
  assign BUS_rresp       = bus_rsp;

  always @(posedge clk) begin
    if (rst) begin
      bcnt  <= 0;
      bpend <= 1'b0;
    end else begin
      if (BUS_raddr_valid && !BUS_raddr_ready)
        bcnt <= bcnt + 1;
      else
        bcnt <= 0;
      if (BUS_raddr_valid && BUS_raddr_ready)
        bpend <= 1'b1;
      else if (bpend && BUS_rdata_ready)
        bpend <= 1'b0;
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, got, exp);
    end
  endtask

  // One read: drive, push expectation, wait, compare
  task automatic do_read(input logic [31:0] a,
                         input bit          exp_clint,
                         input logic [63:0] exp_data,
                         input logic [1:0]  exp_resp,
                         input bit          approx,
                         input int          hold,
                         input int          exp_lat);
    int          k;
    int          c0;
    bit          moved;
    exp_t        e;
    logic [63:0] d0;
    c0 = clint_vcnt;
    @(negedge clk);
    MEM_raddr       = a;
    MEM_rsize       = 3'd3;
    MEM_raddr_valid = 1'b1;
    sb.push_back('{exp_data, exp_resp, approx});
    chk("ar_ready_idle", 64'(MEM_raddr_ready), 64'd1);
    @(posedge clk);
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        MEM_raddr_valid = 1'b0;
        chk("sel_clint", 64'(CLINT_MEM_raddr_valid),
            64'(exp_clint));
        chk("sel_bus", 64'(BUS_raddr_valid),
            64'(!exp_clint));
        chk("ar_ready_busy", 64'(MEM_raddr_ready), 64'd0);
      end
    end while (!MEM_rdata_valid && k < 60);
    chk("rvalid", 64'(MEM_rdata_valid), 64'd1);
    chk("latency", 64'(k), 64'(exp_lat));
    d0    = MEM_rdata;
    moved = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (MEM_rdata !== d0 || MEM_rdata_valid !== 1'b1)
        moved = 1'b1;
    end
    if (hold > 0) begin
      chk("hold_stable", 64'(moved), 64'd0);
      chk("hold_no_err", 64'(MEM_rresp), 64'(exp_resp));
    end
    e = sb.pop_front();
    if (e.approx)
      chk("mtime_near",
          64'((MEM_rdata - e.data) <= 64'd3), 64'd1);
    else
      chk("rdata", MEM_rdata, e.data);
    chk("rresp", 64'(MEM_rresp), 64'(e.resp));
    if (!exp_clint)
      chk("clint_quiet", 64'(clint_vcnt - c0), 64'd0);
    MEM_rdata_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    MEM_rdata_ready = 1'b0;
    chk("back_idle", 64'(MEM_raddr_ready), 64'd1);
    chk("rvalid_drop", 64'(MEM_rdata_valid), 64'd0);
  endtask

  initial begin
    int k;
    rst             = 1'b1;
    MEM_raddr       = '0;
    MEM_rsize       = '0;
    MEM_raddr_valid = 1'b0;
    MEM_rdata_ready = 1'b0;
    bus_wait        = 0;
    bus_mute        = 1'b0;
    bus_dat         = '0;
    bus_rsp         = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ar_ready", 64'(MEM_raddr_ready), 64'd0);
    chk("rst_rvalid", 64'(MEM_rdata_valid), 64'd0);
    chk("rst_rdata", MEM_rdata, 64'd0);
    chk("rst_rresp", 64'(MEM_rresp), 64'd0);
    chk("rst_clint_v", 64'(CLINT_MEM_raddr_valid), 64'd0);
    chk("rst_clint_r", 64'(CLINT_MEM_rdata_ready), 64'd0);
    chk("rst_bus_v", 64'(BUS_raddr_valid), 64'd0);
    chk("rst_bus_r", 64'(BUS_rdata_ready), 64'd0);
    chk("rst_errcnt", 64'(err_count), 64'd0);
    rst = 1'b0;
    repeat (97) @(posedge clk);

    // CLINT mtime read, zero-wait slave
    do_read(32'h0200_BFF8, 1'b1, mtime, 2'b00,
            1'b1, 0, 2);

    // Bus read with 3 address wait states
    bus_wait = 3;
    bus_dat  = 64'hDEAD_BEEF_0123_4567;
    do_read(32'h8000_0000, 1'b0, 64'hDEAD_BEEF_0123_4567,
            2'b00, 1'b0, 0, 5);

    // CLINT outside mtime never answers
    do_read(32'h0200_0000, 1'b1, 64'd0, 2'b10,
            1'b0, 0, 17);
    chk("errcnt_1", 64'(err_count), 64'd1);

    // Long master backpressure is not a timeout
    bus_wait = 0;
    bus_dat  = 64'h1122_3344_5566_7788;
    do_read(32'h8000_1000, 1'b0, 64'h1122_3344_5566_7788,
            2'b00, 1'b0, 40, 2);
    chk("errcnt_bp", 64'(err_count), 64'd1);

    // Bus error response forwarded
    bus_wait = 1;
    bus_rsp  = 2'b10;
    bus_dat  = 64'h0BAD_0BAD_0BAD_0BAD;
    do_read(32'h9000_0008, 1'b0, 64'h0BAD_0BAD_0BAD_0BAD,
            2'b10, 1'b0, 0, 3);
    bus_rsp  = 2'b00;
    chk("errcnt_slverr", 64'(err_count), 64'd1);

    // Decode boundaries
    do_read(32'h0200_FFFF, 1'b1, 64'd0, 2'b10,
            1'b0, 0, 17);
    chk("errcnt_2", 64'(err_count), 64'd2);
    bus_wait = 0;
    bus_dat  = 64'hA5A5_0000_0201_0000;
    do_read(32'h0201_0000, 1'b0, 64'hA5A5_0000_0201_0000,
            2'b00, 1'b0, 0, 2);
    bus_dat  = 64'h5A5A_0000_01FF_FFFF;
    do_read(32'h01FF_FFFF, 1'b0, 64'h5A5A_0000_01FF_FFFF,
            2'b00, 1'b0, 0, 2);
    bus_dat  = 64'hFFFF_FFF8_0000_0001;
    do_read(32'hFFFF_FFF8, 1'b0, 64'hFFFF_FFF8_0000_0001,
            2'b00, 1'b0, 0, 2);

    // Silent bus times out in ADDR
    bus_mute = 1'b1;
    do_read(32'h8000_2000, 1'b0, 64'd0, 2'b10,
            1'b0, 0, 17);
    chk("errcnt_3", 64'(err_count), 64'd3);
    bus_mute = 1'b0;

    // Reset while in DATA with data pending
    bus_wait = 2;
    bus_dat  = 64'hCAFE_F00D_CAFE_F00D;
    @(negedge clk);
    MEM_raddr       = 32'h8000_3000;
    MEM_raddr_valid = 1'b1;
    @(posedge clk);
    k = 0;
    do begin
      @(negedge clk);
      k++;
      MEM_raddr_valid = 1'b0;
    end while (!MEM_rdata_valid && k < 60);
    chk("pre_rst_rvalid", 64'(MEM_rdata_valid), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_rvalid", 64'(MEM_rdata_valid), 64'd0);
    chk("mid_rst_bus_r", 64'(BUS_rdata_ready), 64'd0);
    chk("mid_rst_bus_v", 64'(BUS_raddr_valid), 64'd0);
    chk("mid_rst_ar", 64'(MEM_raddr_ready), 64'd0);
    chk("mid_rst_errcnt", 64'(err_count), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ar", 64'(MEM_raddr_ready), 64'd1);
    chk("post_rst_rvalid", 64'(MEM_rdata_valid), 64'd0);

    // Still works after the aborted read
    bus_wait = 0;
    bus_dat  = 64'h0123_4567_89AB_CDEF;
    do_read(32'h8000_4000, 1'b0, 64'h0123_4567_89AB_CDEF,
            2'b00, 1'b0, 0, 2);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

  // Hard bound on total run time
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
